// File: rtl/mem_bus_arbiter.sv
// Round-robin N-master to 1-slave memory bus arbiter with a registered request
// latch, a configurable slave read latency and a one-cycle acknowledge pulse.
module mem_bus_arbiter #(
  parameter int NMASTERS     = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic [NMASTERS-1:0]           iReq,
  input  logic [NMASTERS-1:0]           iWrite,
  input  logic [NMASTERS*DATA_W/8-1:0]  iByteEnable,
  input  logic [NMASTERS*ADDR_W-1:0]    iAddress,
  input  logic [NMASTERS*DATA_W-1:0]    iWriteData,
  output logic [NMASTERS-1:0]           oAck,
  output logic [NMASTERS-1:0]           oGrant,
  output logic [DATA_W-1:0]             oReadData,
  output logic                          oBusy,
  output logic                          oMReadEnable,
  output logic                          oMWriteEnable,
  output logic [DATA_W/8-1:0]           oMByteEnable,
  output logic [ADDR_W-1:0]             oMAddress,
  output logic [DATA_W-1:0]             oMWriteData,
  input  logic [DATA_W-1:0]             iMReadData
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NMASTERS);
  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               write_q, write_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;
  logic               sel_write;
  logic [BE_W-1:0]    sel_be;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Search starts one past the last owner, so the previous winner is checked last.
  always_comb begin
    // NOTE: every combinational output gets a default first; a missed branch would otherwise infer a latch.
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NMASTERS; i++) begin
      cand     = (int'(last_q) + i) % NMASTERS;
      cand_idx = IDX_W'(cand);
      if (!found && iReq[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NMASTERS; k++) begin
      if (win_idx == IDX_W'(k)) begin
        sel_write = iWrite[k];
        sel_be    = iByteEnable[k*BE_W +: BE_W];
        sel_addr  = iAddress[k*ADDR_W +: ADDR_W];
        sel_wdata = iWriteData[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge iCLK) begin
    // NOTE: the datapath latch is reset too, since every output must read 0 straight after reset.
    if (!iRST) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NMASTERS - 1);
      write_q <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      write_q <= write_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    write_d = write_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ACCESS;
          owner_d = win_idx;
          write_d = sel_write;
          be_d    = sel_be;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      ACCESS: begin
        if (write_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(READ_LATENCY);
        end
      end
      WAIT: begin
        // Counter runs READ_LATENCY down to 1; the slave data is valid in the count-1 cycle.
        if (cnt_q == CNT_W'(1)) begin
          rdata_d = iMReadData;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oGrant = '0;
    oAck   = '0;
    if (state_q != IDLE) oGrant[owner_q] = 1'b1;
    if (state_q == DONE) oAck[owner_q]   = 1'b1;
    oBusy         = (state_q != IDLE);
    oMReadEnable  = (state_q == ACCESS) && !write_q;
    oMWriteEnable = (state_q == ACCESS) && write_q;
    oMByteEnable  = (state_q == ACCESS) ? be_q : '0;
    oMAddress     = addr_q;
    oMWriteData   = wdata_q;
    oReadData     = rdata_q;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised N-master to 1-slave memory bus arbiter for the softcore memory subsystem. It generalises the fixed instruction/data split: any number of requesters, such as instruction fetch, data port, debug loader or DMA, share one Memory_Interface-style port. Arbitration is round-robin, with a registered request latch and a configurable slave read latency. Each transfer completes with a one-cycle acknowledge pulse to the owning master.

## Interface
Parameters:
- NMASTERS, 2: number of requesting masters, ≥2
- ADDR_W, 32: address width
- DATA_W, 32: data width; byte-enable width is DATA_W/8
- READ_LATENCY, 1: cycles from the slave read-enable cycle to valid iMReadData, ≥1

Ports:
- iCLK  in  1  single core clock; all logic on rising edge
- iRST  in  1  reset, synchronous, active-low
- iReq  in  NMASTERS  per-master request; held until that master's oAck
- iWrite  in  NMASTERS  per-master direction: 1 = write, 0 = read
- iByteEnable  in  NMASTERS*DATA_W/8  packed per-master byte enables; master k in slice k
- iAddress  in  NMASTERS*ADDR_W  packed per-master addresses
- iWriteData  in  NMASTERS*DATA_W  packed per-master write data
- oAck  out  NMASTERS  one-hot, one-cycle transfer-complete pulse
- oGrant  out  NMASTERS  one-hot current owner
- oReadData  out  DATA_W  read data, valid while oAck is high for a read
- oBusy  out  1  high whenever state ≠ IDLE
- oMReadEnable  out  1  slave read strobe
- oMWriteEnable  out  1  slave write strobe
- oMByteEnable  out  DATA_W/8  slave byte enables
- oMAddress  out  ADDR_W  slave address
- oMWriteData  out  DATA_W  slave write data
- iMReadData  in  DATA_W  slave read data

## Operation
- The FSM has four states: IDLE, ACCESS, WAIT, DONE.
- **IDLE:**
  - If any iReq bit is set, select the winner by round-robin, starting at (last+1) mod NMASTERS.
  - Latch the winner's index, direction, byte enables, address and write data, then go to ACCESS.
  - If no iReq bit is set, stay in IDLE.
- **ACCESS:** lasts exactly 1 cycle.
  - Drive oMAddress, oMWriteData and oMByteEnable from the latch.
  - Assert oMWriteEnable for a write or oMReadEnable for a read.
  - A write goes to DONE; a read goes to WAIT.
- **WAIT:** lasts READ_LATENCY cycles, using a counter of width clog2(READ_LATENCY+1).
  - On the last WAIT cycle, capture iMReadData into the read-data register, then go to DONE.
- **DONE:** lasts 1 cycle.
  - oAck[owner] = 1; for a read, oReadData holds the captured data.
  - Update last = owner, then return to IDLE.
  - No arbitration takes place in DONE. The acked master must drop iReq, or present a new request, by the IDLE cycle that follows.
- oGrant is one-hot for the owner from ACCESS through DONE, and 0 in IDLE.
- Slave strobes are high only in ACCESS. oMByteEnable is 0 outside ACCESS. oMAddress and oMWriteData hold their latched values outside ACCESS.
- Changes to iReq or iAddress while a transfer is in flight have no effect on it; the request fields were latched in IDLE.
- A request with all-zero byte enables is still performed and acked.

## Timing
- Reset (iRST = 0 at a rising edge):
  - Next cycle: state = IDLE and last = NMASTERS-1, so master 0 wins the first arbitration.
  - All outputs are 0, including oReadData and the latch.
- Reset mid-transfer aborts it: no oAck, and strobes are low from the next cycle.
- Write latency, with the request seen in IDLE at cycle 0:
  - ACCESS at cycle 1; oAck at cycle 2.
  - Throughput: 1 write per 3 cycles.
- Read latency:
  - ACCESS at cycle 1; WAIT in cycles 2..1+READ_LATENCY.
  - iMReadData is sampled at the end of cycle 1+READ_LATENCY.
  - oAck and oReadData at cycle 2+READ_LATENCY.
- Simultaneous requests: exactly one grant per arbitration. Losers stay pending and win in round-robin order, so there is no starvation.
- Pointer wrap: when last = NMASTERS-1, the search begins at master 0.

## Test plan
- **Single write:** master 0 writes A=0x10010000, D=0xDEADBEEF, BE=4'hF, with the request at cycle 0.
  - Cycle 1: oMWriteEnable = 1 with those values and oGrant = 2'b01.
  - Cycle 2: oAck = 2'b01.
- **Read, READ_LATENCY=2:** master 1 reads A=0x00400000; the slave returns 0x12345678 in cycle 3.
  - Cycle 4: oAck = 2'b10 and oReadData = 0x12345678.
  - Strobes are low in cycles 2-4.
- **Two-master fairness, NMASTERS=2:** both masters hold requests continuously and re-request after each ack.
  - Grant order is 0,1,0,1; every transfer completes as above.
- **Four-master wrap, NMASTERS=4:** all masters request.
  - Grants go 0,1,2,3,0.
  - If master 2 drops its request, the order becomes 0,1,3,0.
- **Reset mid-read:** pull iRST low during WAIT.
  - Next cycle: state = IDLE, oBusy = 0, no oAck, all outputs 0.
  - The next request is granted to master 0.
- **Back-to-back, single requester:** master 0 issues a new request in the IDLE cycle right after DONE.
  - The second ACCESS occurs 2 cycles after the first oAck.
  - No duplicate ack; the second transfer uses the new address.
